// File: rtl/jtopl_pkg.sv
// Shared slot/channel definitions for the OPL phase-generator scheduler.
package jtopl_pkg;
    localparam int SLOT_W = 5;
    localparam int CH_W   = 4;

    typedef enum logic { OP_MOD = 1'b0, OP_CAR = 1'b1 } op_e;

    typedef struct packed {
        op_e             op;
        logic [CH_W-1:0] ch;
    } slot_map_t;

    // Slots 0..CH-1 are modulators, CH..2*CH-1 the carriers of the same channels.
    function automatic slot_map_t slot_map(input logic [SLOT_W-1:0] slot, input int ch_n);
        logic [SLOT_W-1:0] n;
        slot_map_t m;
        n    = SLOT_W'(ch_n);
        m.op = (slot >= n) ? OP_CAR : OP_MOD;
        m.ch = (slot >= n) ? CH_W'(slot - n) : CH_W'(slot);
        return m;
    endfunction
endpackage

// File: rtl/jtopl_slot_cnt.sv
// Mod-2*CH operator slot counter with registered channel/operator decode.
module jtopl_slot_cnt
    import jtopl_pkg::*;
#(
    parameter int CH = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cenop,
    output logic [SLOT_W-1:0] slot,
    output logic [CH_W-1:0]   ch,
    output logic              op,
    output logic              zero,
    output logic [CH_W-1:0]   nxt_ch
);
    logic [SLOT_W-1:0] nxt_slot;
    slot_map_t         nxt_map;

    always_comb begin
        nxt_slot = (slot == SLOT_W'(2*CH-1)) ? '0 : slot + 1'b1;
        nxt_map  = slot_map(nxt_slot, CH);
        nxt_ch   = nxt_map.ch;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot <= '0;
            ch   <= '0;
            op   <= 1'b0;
            zero <= 1'b1;
        end else if (cenop) begin
            slot <= nxt_slot;
            ch   <= nxt_map.ch;
            op   <= nxt_map.op;
            zero <= (nxt_slot == '0);
        end
    end
endmodule

// File: rtl/jtopl_pg_sched.sv
// Slot sequencer plus key-on bank: turns CPU key writes into stage-II phase resets.
module jtopl_pg_sched
    import jtopl_pkg::*;
#(
    parameter int CH = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cenop,
    input  logic              kon_we,
    input  logic [3:0]        kon_ch,
    input  logic              kon_val,
    output logic [4:0]        slot_I,
    output logic [3:0]        ch_I,
    output logic              op_I,
    output logic              zero_I,
    output logic              kon_I,
    output logic              pg_rst_II,
    output logic [2*CH-1:0]   kon_pend
);
    logic [CH-1:0]   keys;
    logic [CH-1:0]   rise_c, off_c;
    logic [CH_W-1:0] nxt_ch;
    logic            hit_rise, hit_off, svc_pend, nxt_kon;

    jtopl_slot_cnt #(.CH(CH)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .cenop  (cenop),
        .slot   (slot_I),
        .ch     (ch_I),
        .op     (op_I),
        .zero   (zero_I),
        .nxt_ch (nxt_ch)
    );

    // Out-of-range channels never match a decode term, so those writes fall away.
    always_comb begin
        rise_c   = '0;
        off_c    = '0;
        hit_rise = 1'b0;
        hit_off  = 1'b0;
        svc_pend = 1'b0;
        nxt_kon  = 1'b0;
        for (int c = 0; c < CH; c++) begin
            if (kon_we && kon_ch == CH_W'(c)) begin
                rise_c[c] = kon_val && !keys[c];
                off_c[c]  = !kon_val;
            end
            if (ch_I == CH_W'(c)) begin
                hit_rise = rise_c[c];
                hit_off  = off_c[c];
            end
            if (nxt_ch == CH_W'(c))
                nxt_kon = keys[c];
        end
        for (int s = 0; s < 2*CH; s++)
            if (slot_I == SLOT_W'(s))
                svc_pend = kon_pend[s];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            keys      <= '0;
            kon_pend  <= '0;
            kon_I     <= 1'b0;
            pg_rst_II <= 1'b0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (rise_c[c])
                    keys[c] <= 1'b1;
                else if (off_c[c])
                    keys[c] <= 1'b0;
            end
            // Pending index equals slot index; the service clear comes last so a
            // same-clock rising write on the serviced slot is consumed by the bypass.
            for (int o = 0; o < 2; o++) begin
                for (int c = 0; c < CH; c++) begin
                    if (rise_c[c])
                        kon_pend[o*CH+c] <= 1'b1;
                    if (off_c[c])
                        kon_pend[o*CH+c] <= 1'b0;
                    if (cenop && slot_I == SLOT_W'(o*CH+c))
                        kon_pend[o*CH+c] <= 1'b0;
                end
            end
            if (cenop) begin
                pg_rst_II <= (svc_pend || hit_rise) && !hit_off;
                kon_I     <= nxt_kon;
            end
        end
    end
endmodule

// File: tb/tb_jtopl_pg_sched.sv
// Self-checking bench: vector table, directed corner sequences, random run against a model.
module tb_jtopl_pg_sched;
    localparam int CH = 9;
    localparam int NS = 2*CH;

    logic            clk = 1'b0, rst = 1'b0, cenop = 1'b0, kon_we = 1'b0, kon_val = 1'b0;
    logic [3:0]      kon_ch = '0;
    logic [4:0]      slot_I;
    logic [3:0]      ch_I;
    logic            op_I, zero_I, kon_I, pg_rst_II;
    logic [NS-1:0]   kon_pend;

    jtopl_pg_sched #(.CH(CH)) dut (
        .clk(clk), .rst(rst), .cenop(cenop), .kon_we(kon_we), .kon_ch(kon_ch),
        .kon_val(kon_val), .slot_I(slot_I), .ch_I(ch_I), .op_I(op_I), .zero_I(zero_I),
        .kon_I(kon_I), .pg_rst_II(pg_rst_II), .kon_pend(kon_pend)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    // Reference state: slot position, stored keys, pending resets per {op,ch}.
    int m_slot;
    bit m_key[CH];
    bit m_pend[NS];
    bit m_kon, m_rst;

    typedef struct {
        bit cen; bit we; int ch; bit val;
        int slot; bit rst;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_slot = 0; m_kon = 0; m_rst = 0;
        for (int i = 0; i < CH; i++) m_key[i] = 0;
        for (int i = 0; i < NS; i++) m_pend[i] = 0;
    endtask

    task automatic model_edge(input bit cen, input bit we, input int ch, input bit val);
        bit rise, off;
        int svc, sc;
        rise = 0; off = 0;
        if (we && ch < CH) begin
            rise = val && !m_key[ch];
            off  = !val;
        end
        svc = m_slot;
        sc  = svc % CH;
        if (cen) begin
            m_rst  = (m_pend[svc] || (rise && ch == sc)) && !(off && ch == sc);
            m_slot = (m_slot + 1) % NS;
            m_kon  = m_key[m_slot % CH];
        end
        if (rise) begin m_key[ch] = 1; m_pend[ch] = 1; m_pend[ch+CH] = 1; end
        if (off)  begin m_key[ch] = 0; m_pend[ch] = 0; m_pend[ch+CH] = 0; end
        if (cen) m_pend[svc] = 0;
    endtask

    function automatic logic [NS-1:0] exp_pend();
        logic [NS-1:0] v;
        for (int i = 0; i < NS; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_slot"}, 32'(slot_I), 32'(m_slot));
        chk({tag, "_ch"},   32'(ch_I),   32'(m_slot % CH));
        chk({tag, "_op"},   32'(op_I),   32'(m_slot >= CH));
        chk({tag, "_zero"}, 32'(zero_I), 32'(m_slot == 0));
        chk({tag, "_kon"},  32'(kon_I),  32'(m_kon));
        chk({tag, "_rst"},  32'(pg_rst_II), 32'(m_rst));
        chk({tag, "_pend"}, 32'(kon_pend), 32'(exp_pend()));
    endtask

    task automatic step(input bit cen, input bit we, input int ch, input bit val, input string tag);
        cenop = cen; kon_we = we; kon_ch = 4'(ch); kon_val = val;
        @(posedge clk);
        model_edge(cen, we, ch, val);
        #1;
        check_all(tag);
        cenop = 0; kon_we = 0;
    endtask

    task automatic goto_slot(input int s);
        for (int k = 0; k < NS && m_slot != s; k++) step(1, 0, 0, 0, "seek");
    endtask

    initial begin
        int pulses, first_svc, second_svc, prev;
        model_reset();
        tbl[0] = '{1, 0, 0, 0, 1, 0};
        tbl[1] = '{0, 1, 3, 1, 1, 0};
        tbl[2] = '{1, 0, 0, 0, 2, 0};
        tbl[3] = '{1, 0, 0, 0, 3, 0};
        tbl[4] = '{1, 0, 0, 0, 4, 1};
        tbl[5] = '{0, 1, 4, 1, 4, 1};
        tbl[6] = '{1, 0, 0, 0, 5, 1};
        tbl[7] = '{1, 0, 0, 0, 6, 0};
        tbl[8] = '{1, 1, 12, 1, 7, 0};

        #12;
        check_all("reset");
        @(negedge clk) rst = 1;

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].cen, tbl[i].we, tbl[i].ch, tbl[i].val, "tbl");
            chk("tbl_slot_vec", 32'(slot_I), 32'(tbl[i].slot));
            chk("tbl_rst_vec", 32'(pg_rst_II), 32'(tbl[i].rst));
        end

        // 1: asynchronous reset in the middle of a run
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, "t1_run");
        #2 rst = 0;
        #1;
        chk("t1_async_slot", 32'(slot_I), 0);
        chk("t1_async_zero", 32'(zero_I), 1);
        chk("t1_async_rst", 32'(pg_rst_II), 0);
        chk("t1_async_pend", 32'(kon_pend), 0);
        model_reset();
        @(negedge clk) rst = 1;
        for (int i = 0; i < NS + 1; i++) begin
            step(1, 0, 0, 0, "t1_count");
            chk("t1_seq", 32'(slot_I), 32'((i + 1) % NS));
        end

        // 2: key-on ch3 written while slot_I is 0
        goto_slot(0);
        step(0, 1, 3, 1, "t2_wr");
        pulses = 0; first_svc = -1; second_svc = -1;
        for (int i = 0; i < NS + 2; i++) begin
            prev = int'(slot_I);
            step(1, 0, 0, 0, "t2");
            if (pg_rst_II) begin
                pulses++;
                if (pulses == 1) begin
                    first_svc = prev;
                    chk("t2_pend3_clr", 32'(kon_pend[3]), 0);
                    chk("t2_pend12_set", 32'(kon_pend[12]), 1);
                end else second_svc = prev;
            end
        end
        chk("t2_pulses", 32'(pulses), 2);
        chk("t2_mod_slot", 32'(first_svc), 3);
        chk("t2_car_slot", 32'(second_svc), 12);

        // 3: bypass when the write coincides with servicing slot 5
        goto_slot(5);
        step(1, 1, 5, 1, "t3");
        chk("t3_bypass", 32'(pg_rst_II), 1);
        chk("t3_pend5", 32'(kon_pend[5]), 0);
        chk("t3_pend14", 32'(kon_pend[14]), 1);
        goto_slot(14);
        chk("t3_pend14_hold", 32'(kon_pend[14]), 1);
        step(1, 0, 0, 0, "t3_car");
        chk("t3_car_rst", 32'(pg_rst_II), 1);

        // 4: key-on then key-off of ch2 before it is serviced
        goto_slot(0);
        step(0, 1, 2, 1, "t4_on");
        step(1, 0, 0, 0, "t4_mid");
        step(0, 1, 2, 0, "t4_off");
        pulses = 0;
        for (int i = 0; i < NS + 1; i++) begin
            step(1, 0, 0, 0, "t4");
            pulses += int'(pg_rst_II);
            if (slot_I == 2 || slot_I == 11) chk("t4_kon", 32'(kon_I), 0);
        end
        chk("t4_pulses", 32'(pulses), 0);

        // 5: retrigger of a held key and an out-of-range channel
        step(0, 1, 7, 1, "t5_on");
        for (int i = 0; i < NS + 1; i++) step(1, 0, 0, 0, "t5_drain");
        step(0, 1, 7, 1, "t5_hold");
        step(0, 1, 12, 1, "t5_bad");
        chk("t5_pend", 32'(kon_pend), 0);
        pulses = 0;
        for (int i = 0; i < NS + 1; i++) begin
            step(1, 0, 0, 0, "t5");
            pulses += int'(pg_rst_II);
            if (slot_I == 7) chk("t5_kon7", 32'(kon_I), 1);
        end
        chk("t5_pulses", 32'(pulses), 0);

        // 6: cenop at 1/4 duty with writes landing between enables
        for (int k = 0; k < 16*NS; k++)
            step(k % 4 == 3, (k % 4 == 1) && ($urandom_range(0, 1) == 1),
                 int'($urandom_range(0, CH-1)), $urandom_range(0, 3) != 0, "t6");

        // random run
        for (int k = 0; k < 3000; k++)
            step($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                 int'($urandom_range(0, 15)), $urandom_range(0, 2) != 0, "rnd");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/jtopl_pg_sched.md
Name: jtopl_pg_sched

Overview:
Slot sequencer and key-on scheduler for the phase-generator pipeline. It walks the 2*CH operator slots on every cenop and presents channel/operator indices at stage I. It turns asynchronous CPU key-on writes into per-operator phase-reset pulses, timed at stage II. It feeds the fnum/block/mul register-file reads and the pg_rst_II input of the phase generator, and supplies the key state to the envelope generator.

Parameters:
CH, 9, number of channels; slot count is 2*CH; legal range is 1..15.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset (asserted when 0)
cenop  in  1  operator clock enable; one slot advance per cenop
kon_we  in  1  key write strobe, single clk, independent of cenop
kon_ch  in  4  channel addressed by kon_we
kon_val  in  1  new key state for kon_ch (1 = on)
slot_I  out  5  current slot index, 0..2*CH-1
ch_I  out  4  channel of current slot
op_I  out  1  0 = modulator, 1 = carrier
zero_I  out  1  high while slot_I==0
kon_I  out  1  key state of ch_I
pg_rst_II  out  1  phase-reset pulse for the slot now in stage II
kon_pend  out  2*CH  pending-reset bits, index {op,ch} = op*CH+ch (debug/verification)

Behaviour:
- Reset (rst=0, async) sets:
  - slot_I=0, ch_I=0, op_I=0, zero_I=1, kon_I=0, pg_rst_II=0.
  - All key-state bits=0 and all pending bits=0.
- Slot counter:
  - Advances only on clk edges where cenop=1.
  - slot_I = slot_I+1; wraps from 2*CH-1 to 0.
  - Mapping: op_I = (slot_I >= CH); ch_I = op_I ? slot_I-CH : slot_I.
  - All stage-I outputs are registered and change together, on the same cenop edge as slot_I.
- Key writes:
  - Accepted on any clk edge where kon_we=1.
  - kon_ch >= CH: write is ignored; no state changes.
  - Rising key (stored 0, kon_val=1): stored key set to 1; both pending bits of the channel set.
  - Key held (1->1): no effect; no retrigger.
  - Key-off (kon_val=0): stored key cleared; both pending bits of the channel cleared, so no reset is issued for a released key.
- Reset issue:
  - On a cenop edge, the slot leaving stage I (the current ch_I/op_I) moves to stage II.
  - pg_rst_II <= pending bit of that {op,ch}, OR a rising key write on that channel in the same clk.
  - The serviced pending bit is cleared on the same edge.
  - pg_rst_II holds its value until the next cenop edge, so it aligns with the phase-generator stage-II register.
- Simultaneous events:
  - A rising write to channel c in the same clk that slot {op,c} is serviced: the reset is issued immediately (bypass) and that op's pending bit ends at 0. The other op's bit is set normally.
  - A key-off in the same clk that slot {op,c} is serviced: the key-off wins and pg_rst_II=0.
- Latency:
  - A key-on rising write reaches pg_rst_II for the modulator within at most 2*CH cenop edges.
  - The carrier follows exactly CH cenop edges after the modulator.
- kon_I reflects the stored key state of ch_I, sampled at the same edge as ch_I. A write takes effect at the next slot visit.
- No combinational path exists from inputs to outputs.

Decomposition:
- Shared package jtopl_pkg:
  - slot/channel width constants (SLOT_W=5, CH_W=4);
  - the OP_MOD/OP_CAR encodings;
  - the function mapping slot to {op,ch}.
- Sub-module jtopl_slot_cnt: mod-2*CH counter producing slot_I/ch_I/op_I/zero_I.
- This block keeps the key-state/pending bank and the pg_rst stage-II register.

Test Plan:
1. Reset mid-run: hold cenop=1 for 7 cycles, pull rst low between edges. Required: all outputs return to reset values immediately (async); after release, slot_I counts 0,1,…,17,0 with zero_I high only at 0.
2. Key-on ch3 written while slot_I=0. Required:
   - pg_rst_II=1 for exactly the cenop period following slot 3 (mod);
   - then again after slot 12 (car);
   - kon_pend[3] and kon_pend[12] clear, in turn, as each reset is issued.
3. Key-on ch5 written in the same clk that slot_I=5 advances. Required: pg_rst_II=1 next period (bypass); kon_pend[5]=0; kon_pend[14]=1 until slot 14.
4. Key-on ch2 then key-off ch2 before slot 2 is reached. Required: no pg_rst_II pulse for either op; kon_I=0 at slots 2 and 11.
5. Key-on to an already-on channel 7, plus a write with kon_ch=12. Required: no pending bits set, no pg_rst_II pulses, stored keys unchanged.
6. cenop duty 1/4 with kon_we pulses between enables. Required: slot advances only on enabled edges; all write events are captured; pg_rst_II width equals one full cenop period.
